memu_pipe_ctrl: RTL and testbench

// - Parametrised, clocked successor of the memory unit: single-port word RAM with valid/ready request handshake,

---
 rtl/memu_pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_memu_pipe_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memu_pipe_ctrl.sv
// Single-port word RAM with valid/ready requests, RD_LAT-stage read pipe and a clear engine.
// Define MEMU_WMASK_EN to add the Req_mask nibble write-enable port.
module memu_pipe_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              Global_clk,
  input  logic              Global_rst_n,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic              Req_write,
  input  logic [ADDR_W-1:0] Req_addr,
  input  logic [DATA_W-1:0] Req_data,
`ifdef MEMU_WMASK_EN
  input  logic [DATA_W/4-1:0] Req_mask,
`endif
  output logic              Rsp_valid,
  output logic [DATA_W-1:0] Rsp_data,
  input  logic              Clear_start,
  output logic              Clear_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              rd_accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] merged;

  logic [RD_LAT-1:0] pvalid_q;
  logic [DATA_W-1:0] pdata_q [RD_LAT];

  // Ready is forced low while reset is held, independent of the FSM.
  assign Req_ready  = Global_rst_n & (state_q == ST_IDLE);
  assign accept     = Req_valid & Req_ready;
  assign rd_accept  = accept & ~Req_write;
  assign Clear_busy = (state_q == ST_CLEAR);

  always_comb begin
    merged = Req_data;
`ifdef MEMU_WMASK_EN
    for (int k = 0; k < DATA_W / 4; k++) begin
      if (!Req_mask[k]) begin
        merged[4*k +: 4] = mem_q[Req_addr][4*k +: 4];
      end
    end
`endif
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = Req_addr;
    wr_data = merged;
    if (state_q == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = '0;
    end else if (accept && Req_write) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge Global_clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A request accepted alongside Clear_start completes on the same edge the FSM enters CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Global_clk or negedge Global_rst_n) begin
    if (!Global_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data stages only advance behind a valid entry, so the last stage holds the previous response.
  always_ff @(posedge Global_clk or negedge Global_rst_n) begin
    if (!Global_rst_n) begin
      pvalid_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pdata_q[i] <= '0;
      end
    end else begin
      pvalid_q[0] <= rd_accept;
      if (rd_accept) begin
        pdata_q[0] <= mem_q[Req_addr];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pvalid_q[i] <= pvalid_q[i-1];
        if (pvalid_q[i-1]) begin
          pdata_q[i] <= pdata_q[i-1];
        end
      end
    end
  end

  assign Rsp_valid = pvalid_q[RD_LAT-1];
  assign Rsp_data  = pdata_q[RD_LAT-1];

endmodule

// File: tb/tb_memu_pipe_ctrl.sv
// Directed bench for memu_pipe_ctrl built with RD_LAT=2: vector table plus clear/reset sequences.
// The masked-write sequence runs only when MEMU_WMASK_EN is defined.
module tb_memu_pipe_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              Req_valid;
  logic              Req_ready;
  logic              Req_write;
  logic [ADDR_W-1:0] Req_addr;
  logic [DATA_W-1:0] Req_data;
`ifdef MEMU_WMASK_EN
  logic [DATA_W/4-1:0] Req_mask;
`endif
  logic              Rsp_valid;
  logic [DATA_W-1:0] Rsp_data;
  logic              Clear_start;
  logic              Clear_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              vld;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              expV;
    logic [DATA_W-1:0] expD;
  } vec_t;

  vec_t vecs [20];

  memu_pipe_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .Global_clk   (clk),
    .Global_rst_n (rst_n),
    .Req_valid    (Req_valid),
    .Req_ready    (Req_ready),
    .Req_write    (Req_write),
    .Req_addr     (Req_addr),
    .Req_data     (Req_data),
`ifdef MEMU_WMASK_EN
    .Req_mask     (Req_mask),
`endif
    .Rsp_valid    (Rsp_valid),
    .Rsp_data     (Rsp_data),
    .Clear_start  (Clear_start),
    .Clear_busy   (Clear_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input logic clr);
    Req_valid   = vld;
    Req_write   = wr;
    Req_addr    = addr;
    Req_data    = data;
    Clear_start = clr;
  endtask

  // Entry and exit point of every helper is 1 time unit after a rising edge.
  task automatic doWrite(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         input logic [3:0] mask);
`ifdef MEMU_WMASK_EN
    Req_mask = mask;
`endif
    applyStimulus(1'b1, 1'b1, addr, data, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
`ifdef MEMU_WMASK_EN
    Req_mask = '1;
`endif
  endtask

  task automatic doRead(input string name, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
    int lat;
    lat = 0;
    applyStimulus(1'b1, 1'b0, addr, '0, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 1; i <= RD_LAT + 3; i++) begin
      @(negedge clk);
      if (Rsp_valid) begin
        lat = i;
        break;
      end
    end
    checkOutput({name, "_latency"}, lat, RD_LAT);
    checkOutput({name, "_data"}, Rsp_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int busy;
    int readyBad;
    int seen;
    bit done;

    vecs[0]  = '{1'b1, 1'b1, 8'h0F, 16'hF00F, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 8'h01, 16'hAAAA, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 8'h02, 16'hBBBB, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 8'h03, 16'hCCCC, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 8'h0F, 16'h0000, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 8'h0F, 16'hDEAD, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 8'h01, 16'h0000, 1'b1, 16'hF00F};
    vecs[7]  = '{1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, 16'hF00F};
    vecs[8]  = '{1'b1, 1'b0, 8'h03, 16'h0000, 1'b1, 16'hAAAA};
    vecs[9]  = '{1'b1, 1'b1, 8'h01, 16'h1111, 1'b1, 16'hBBBB};
    vecs[10] = '{1'b1, 1'b0, 8'h01, 16'h0000, 1'b1, 16'hCCCC};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'hCCCC};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h1111};
    vecs[13] = '{1'b1, 1'b1, 8'hFF, 16'h7777, 1'b0, 16'h1111};
    vecs[14] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h1111};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h1111};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h7777};
    vecs[17] = '{1'b1, 1'b0, 8'h0F, 16'h0000, 1'b0, 16'h7777};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h7777};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'hF00F};

    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
`ifdef MEMU_WMASK_EN
    Req_mask = '1;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", Req_ready, 1'b0);
    checkOutput("reset_rsp_valid", Rsp_valid, 1'b0);
    checkOutput("reset_rsp_data", Rsp_data, 16'h0000);
    checkOutput("reset_clear_busy", Clear_busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("release_ready", Req_ready, 1'b1);
    @(posedge clk); #1;

    // Row k is observed in its own cycle; responses appear RD_LAT rows after their read.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(vecs[k].vld, vecs[k].wr, vecs[k].addr, vecs[k].data, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready", k), Req_ready, 1'b1);
      checkOutput($sformatf("vec%0d_rsp_valid", k), Rsp_valid, vecs[k].expV);
      checkOutput($sformatf("vec%0d_rsp_data", k), Rsp_data, vecs[k].expD);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

    // Full clear, with a stray Clear_start pulse mid-clear that must be ignored.
    doWrite(8'h05, 16'h1234, 4'hF);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    @(posedge clk); #1;
    Clear_start = 1'b0;
    busy = 0;
    readyBad = 0;
    done = 1'b0;
    for (int i = 0; i < DEPTH + 16 && !done; i++) begin
      @(negedge clk);
      if (Clear_busy) begin
        busy++;
        if (Req_ready) readyBad++;
        Clear_start = (busy == 10);
      end else begin
        done = 1'b1;
      end
    end
    Clear_start = 1'b0;
    checkOutput("clear_busy_cycles", busy, DEPTH);
    checkOutput("clear_ready_low", readyBad, 0);
    checkOutput("clear_ended", done, 1'b1);
    @(posedge clk); #1;
    doRead("after_clear_addr05", 8'h05, 16'h0000);
    doRead("after_clear_addrFF", 8'hFF, 16'h0000);

    // Read and Clear_start together, then reset halfway through the clear.
    doWrite(8'hFF, 16'h5A5A, 4'hF);
    doWrite(8'h00, 16'h1234, 4'hF);
    doWrite(8'h10, 16'hBEEF, 4'hF);
    applyStimulus(1'b1, 1'b0, 8'h10, '0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("rdclr_busy_started", Clear_busy, 1'b1);
    checkOutput("rdclr_rsp_not_early", Rsp_valid, 1'b0);
    @(negedge clk);
    checkOutput("rdclr_rsp_valid", Rsp_valid, 1'b1);
    checkOutput("rdclr_rsp_old_data", Rsp_data, 16'hBEEF);
    repeat (DEPTH / 2 - 2) @(negedge clk);
    checkOutput("midclear_busy", Clear_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midclear_reset_busy", Clear_busy, 1'b0);
    checkOutput("midclear_reset_ready", Req_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("midclear_release_ready", Req_ready, 1'b1);
    checkOutput("midclear_release_busy", Clear_busy, 1'b0);
    @(posedge clk); #1;
    doRead("partial_clear_addr00", 8'h00, 16'h0000);
    doRead("partial_clear_addr10", 8'h10, 16'h0000);
    doRead("partial_clear_addrFF", 8'hFF, 16'h5A5A);

    // Reset while a read is in flight drops its response.
    applyStimulus(1'b1, 1'b0, 8'hFF, '0, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midread_reset_rsp_valid", Rsp_valid, 1'b0);
    checkOutput("midread_reset_rsp_data", Rsp_data, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (Rsp_valid) seen = 1;
    end
    checkOutput("midread_no_late_rsp", seen, 0);
    @(posedge clk); #1;

`ifdef MEMU_WMASK_EN
    doWrite(8'h20, 16'hAAAA, 4'hF);
    doWrite(8'h20, 16'h5555, 4'b0101);
    doRead("masked_write", 8'h20, 16'hA5A5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
